cache_ctrl_nway: RTL and testbench

- Parametrised N-way set-associative L1 cache controller; next generation of the existing 2-way load/store cache control signal set.
- Sits between the core load/store request port and the L1 tag/data arrays. Talks to L2 through a req/ack handshake.
- Adds configurable associativity, tree pseudo-LRU replacement, a dirty write-back path and an explicit hit/miss/busy protocol.
- Tag/valid/dirty arrays are external: the controller consumes their read data and drives their write strobes.

---
 rtl/cache_pkg.sv | 59 +++++
 rtl/cache_ctrl_nway_plru.sv | 43 ++++
 rtl/cache_ctrl_nway.sv | 141 ++++++++++++++
 tb/tb_cache_ctrl_nway.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and helpers for the N-way L1 cache controller: FSM states,
// address field extraction and tree pseudo-LRU victim/update arithmetic.
package cache_pkg;

  // Generous upper bound so the helpers serve any legal WAYS up to 64.
  localparam int MAX_LEVELS = 6;

  typedef logic [63:0] wide_t;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WRITEBACK,
    ALLOCATE,
    FILL
  } state_e;

  function automatic wide_t get_tag(input wide_t addr, input int addr_w,
                                    input int index_w, input int offset_w);
    wide_t mask;
    mask = (wide_t'(1) << (addr_w - index_w - offset_w)) - wide_t'(1);
    return (addr >> (index_w + offset_w)) & mask;
  endfunction

  function automatic wide_t get_index(input wide_t addr, input int index_w,
                                      input int offset_w);
    wide_t mask;
    mask = (wide_t'(1) << index_w) - wide_t'(1);
    return (addr >> offset_w) & mask;
  endfunction

  // Tree nodes are heap-ordered: node n has children 2n+1 (left) and 2n+2.
  function automatic int plru_victim(input wide_t bits, input int levels);
    int node;
    node = 0;
    for (int l = 0; l < MAX_LEVELS; l++) begin
      if (l < levels) node = 2 * node + 1 + int'(bits[node[5:0]]);
    end
    return node - ((1 << levels) - 1);
  endfunction

  function automatic wide_t plru_update(input wide_t bits, input int levels,
                                        input int way);
    wide_t nb;
    int    node;
    int    dir;
    nb   = bits;
    node = 0;
    for (int l = 0; l < MAX_LEVELS; l++) begin
      if (l < levels) begin
        dir             = (way >> (levels - 1 - l)) & 1;
        nb[node[5:0]]   = (dir == 0);
        node            = 2 * node + 1 + dir;
      end
    end
    return nb;
  endfunction

endpackage

// File: rtl/cache_ctrl_nway_plru.sv
// Per-set tree pseudo-LRU storage: exposes the victim of the addressed set
// and moves the tree away from the accessed way when update_en is high.
module cache_plru
  import cache_pkg::*;
#(
  parameter int WAYS    = 4,
  parameter int INDEX_W = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [INDEX_W-1:0]       index,
  input  logic [$clog2(WAYS)-1:0]  access_way,
  input  logic                     update_en,
  output logic [$clog2(WAYS)-1:0]  victim
);

  localparam int NUM_SETS = 2 ** INDEX_W;
  localparam int BITS     = WAYS - 1;
  localparam int WAY_W    = $clog2(WAYS);

  logic [BITS-1:0] tree [NUM_SETS];
  logic [BITS-1:0] next_bits;
  wide_t           cur_wide;

  always_comb begin
    cur_wide  = wide_t'(tree[index]);
    next_bits = BITS'(plru_update(cur_wide, WAY_W, int'(access_way)));
    victim    = WAY_W'(plru_victim(cur_wide, WAY_W));
  end

  // NOTE: state uses <= so every flop samples pre-edge values; blocking here
  // would make simulation order-dependent and diverge from the netlist.
  // NOTE: the tree bits are a flop array, not RAM, so they can and must be
  // cleared by reset to give the defined all-zero (way 0) starting victim.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) tree[s] <= '0;
    end else if (update_en) begin
      tree[index] <= next_bits;
    end
  end

endmodule

// File: rtl/cache_ctrl_nway.sv
// N-way set-associative L1 cache controller: one-cycle lookup, PLRU victim
// selection, dirty write-back and L2 line fill with a replayed lookup.
module cache_ctrl_nway
  import cache_pkg::*;
#(
  parameter  int ADDR_W   = 32,
  parameter  int WAYS     = 4,
  parameter  int INDEX_W  = 7,
  parameter  int OFFSET_W = 4,
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ld,
  input  logic                     st,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [WAYS*TAG_W-1:0]    tag_loaded,
  input  logic [WAYS-1:0]          valid,
  input  logic [WAYS-1:0]          dirty,
  input  logic                     l2_ack,
  output logic                     hit,
  output logic                     miss,
  output logic                     load_ready,
  output logic                     write_l1,
  output logic                     read_l2,
  output logic                     write_l2,
  output logic [$clog2(WAYS)-1:0]  way_sel,
  output logic                     busy
);

  localparam int WAY_W = $clog2(WAYS);

  state_e             state_q, state_d;
  logic [TAG_W-1:0]   req_tag_q;
  logic [INDEX_W-1:0] req_index_q;
  logic               req_store_q;
  logic [WAY_W-1:0]   victim_q, victim_d, plru_victim_way;
  logic [WAYS-1:0]    match;
  logic               hit_any, inv_any, victim_dirty, plru_upd;
  logic [WAY_W-1:0]   hit_way, inv_way;

  // Descending scans so the lowest-index way wins on ties.
  always_comb begin
    match   = '0;
    hit_way = '0;
    inv_way = '0;
    for (int w = 0; w < WAYS; w++)
      match[w] = valid[w] && (tag_loaded[w*TAG_W +: TAG_W] == req_tag_q);
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (match[w]) hit_way = WAY_W'(w);
      if (!valid[w]) inv_way = WAY_W'(w);
    end
    hit_any      = |match;
    inv_any      = ~&valid;
    victim_d     = inv_any ? inv_way : plru_victim_way;
    victim_dirty = valid[victim_d] && dirty[victim_d];
  end

  // NOTE: every output and state_d gets a default first, so no path through
  // the case can leave a variable unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    hit        = 1'b0;
    miss       = 1'b0;
    load_ready = 1'b0;
    write_l1   = 1'b0;
    read_l2    = 1'b0;
    write_l2   = 1'b0;
    way_sel    = '0;
    plru_upd   = 1'b0;
    case (state_q)
      IDLE: if (ld || st) state_d = LOOKUP;
      LOOKUP: begin
        if (hit_any) begin
          hit        = 1'b1;
          way_sel    = hit_way;
          load_ready = !req_store_q;
          write_l1   = req_store_q;
          plru_upd   = 1'b1;
          state_d    = IDLE;
        end else begin
          miss    = 1'b1;
          state_d = victim_dirty ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        write_l2 = 1'b1;
        way_sel  = victim_q;
        if (l2_ack) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        read_l2 = 1'b1;
        way_sel = victim_q;
        if (l2_ack) state_d = FILL;
      end
      FILL: begin
        write_l1 = 1'b1;
        way_sel  = victim_q;
        state_d  = LOOKUP;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      req_tag_q   <= '0;
      req_index_q <= '0;
      req_store_q <= 1'b0;
      victim_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && (ld || st)) begin
        req_tag_q   <= TAG_W'(get_tag(wide_t'(addr), ADDR_W, INDEX_W, OFFSET_W));
        req_index_q <= INDEX_W'(get_index(wide_t'(addr), INDEX_W, OFFSET_W));
        req_store_q <= st && !ld;
      end
      if (state_q == LOOKUP && !hit_any) victim_q <= victim_d;
    end
  end

  cache_plru #(
    .WAYS    (WAYS),
    .INDEX_W (INDEX_W)
  ) u_plru (
    .clk        (clk),
    .rst        (rst),
    .index      (req_index_q),
    .access_way (hit_way),
    .update_en  (plru_upd),
    .victim     (plru_victim_way)
  );

  // Duplicate tags in a set mean the arrays were written inconsistently.
  a_single_match: assert property (@(posedge clk) disable iff (rst)
    (state_q == LOOKUP) |-> $onehot0(match));

endmodule

// File: tb/tb_cache_ctrl_nway.sv
// Directed bench for cache_ctrl_nway: a transaction-level model of the tag
// arrays and per-set PLRU predicts the outputs of every cycle.
module tb_cache_ctrl_nway;

  localparam int ADDR_W   = 32;
  localparam int WAYS     = 4;
  localparam int INDEX_W  = 7;
  localparam int OFFSET_W = 4;
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;

  // Output vector order: {hit, miss, load_ready, write_l1, read_l2, write_l2, busy}
  localparam logic [6:0] E_IDLE = 7'b0000000;
  localparam logic [6:0] E_HIT  = 7'b1000000;
  localparam logic [6:0] E_MISS = 7'b0100000;
  localparam logic [6:0] E_LR   = 7'b0010000;
  localparam logic [6:0] E_WL1  = 7'b0001000;
  localparam logic [6:0] E_RL2  = 7'b0000100;
  localparam logic [6:0] E_WL2  = 7'b0000010;
  localparam logic [6:0] E_BUSY = 7'b0000001;

  logic                  clk = 1'b0;
  logic                  rst, ld, st, l2_ack;
  logic [ADDR_W-1:0]     addr;
  logic [WAYS*TAG_W-1:0] tag_loaded;
  logic [WAYS-1:0]       valid, dirty;
  logic                  hit, miss, load_ready, write_l1, read_l2, write_l2, busy;
  logic [1:0]            way_sel;

  always #5 clk = ~clk;

  cache_ctrl_nway #(
    .ADDR_W   (ADDR_W),
    .WAYS     (WAYS),
    .INDEX_W  (INDEX_W),
    .OFFSET_W (OFFSET_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ld         (ld),
    .st         (st),
    .addr       (addr),
    .tag_loaded (tag_loaded),
    .valid      (valid),
    .dirty      (dirty),
    .l2_ack     (l2_ack),
    .hit        (hit),
    .miss       (miss),
    .load_ready (load_ready),
    .write_l1   (write_l1),
    .read_l2    (read_l2),
    .write_l2   (write_l2),
    .way_sel    (way_sel),
    .busy       (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model of the external arrays and the replacement state of each set.
  logic [TAG_W-1:0] m_tag   [128][4];
  bit               m_valid [128][4];
  bit               m_dirty [128][4];
  bit               lru_root [128];
  bit               lru_left [128];
  bit               lru_right[128];
  int               last_hit, last_victim, last_wb;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Compare at the falling edge, then advance to just after the next rising edge.
  task automatic expect_cycle(input string nm, input logic [6:0] e, input int way, input bit chk_way);
    @(negedge clk);
    check(nm, {25'd0, hit, miss, load_ready, write_l1, read_l2, write_l2, busy}, {25'd0, e});
    if (chk_way) check({nm, "_way"}, {30'd0, way_sel}, 32'(way));
    @(posedge clk);
    #1;
  endtask

  function automatic int model_victim(input int s);
    for (int w = 0; w < 4; w++) if (!m_valid[s][w]) return w;
    if (!lru_root[s]) return lru_left[s] ? 1 : 0;
    return lru_right[s] ? 3 : 2;
  endfunction

  task automatic model_touch(input int s, input int w);
    lru_root[s] = (w < 2);
    if (w < 2) lru_left[s] = (w == 0);
    else       lru_right[s] = (w == 2);
  endtask

  task automatic drive_set(input int s);
    for (int w = 0; w < 4; w++) begin
      tag_loaded[w*TAG_W +: TAG_W] = m_tag[s][w];
      valid[w] = m_valid[s][w];
      dirty[w] = m_dirty[s][w];
    end
  endtask

  task automatic clear_lru();
    for (int s = 0; s < 128; s++) begin
      lru_root[s] = 0; lru_left[s] = 0; lru_right[s] = 0;
    end
  endtask

  task automatic access(input string nm, input bit l, input bit s, input int t, input int set,
                        input int wb_dly, input int al_dly, input bit ld_in_alloc, input bit rst_in_wb);
    bit is_st;
    int hw, v;
    is_st = s && !l;
    ld = l; st = s;
    addr = 32'((t << 11) | (set << 4));
    expect_cycle({nm, "_req"}, E_IDLE, 0, 1'b0);
    ld = 1'b0; st = 1'b0;
    drive_set(set);
    hw = -1;
    for (int w = 0; w < 4; w++)
      if (hw < 0 && m_valid[set][w] && int'(m_tag[set][w]) == t) hw = w;
    if (hw < 0) begin
      v = model_victim(set);
      last_victim = v;
      expect_cycle({nm, "_miss"}, E_MISS | E_BUSY, 0, 1'b0);
      if (m_valid[set][v] && m_dirty[set][v]) begin
        last_wb = v;
        if (rst_in_wb) begin
          rst = 1'b1;
          expect_cycle({nm, "_wb_rst"}, E_WL2 | E_BUSY, v, 1'b1);
          clear_lru();
          expect_cycle({nm, "_rst_hold"}, E_IDLE, 0, 1'b1);
          rst = 1'b0;
          expect_cycle({nm, "_rst_rel"}, E_IDLE, 0, 1'b1);
          return;
        end
        for (int i = 0; i <= wb_dly; i++) begin
          l2_ack = (i == wb_dly);
          expect_cycle({nm, "_wb"}, E_WL2 | E_BUSY, v, 1'b1);
        end
        l2_ack = 1'b0;
      end
      for (int i = 0; i <= al_dly; i++) begin
        l2_ack = (i == al_dly);
        ld = ld_in_alloc && (i == 0);
        expect_cycle({nm, "_alloc"}, E_RL2 | E_BUSY, 0, 1'b0);
      end
      l2_ack = 1'b0;
      ld = 1'b0;
      expect_cycle({nm, "_fill"}, E_WL1 | E_BUSY, v, 1'b1);
      m_tag[set][v]   = TAG_W'(t);
      m_valid[set][v] = 1'b1;
      m_dirty[set][v] = 1'b0;
      drive_set(set);
      hw = v;
    end
    expect_cycle({nm, "_hit"}, E_HIT | E_BUSY | (is_st ? E_WL1 : E_LR), hw, 1'b1);
    last_hit = hw;
    model_touch(set, hw);
    if (is_st) m_dirty[set][hw] = 1'b1;
  endtask

  initial begin
    for (int s = 0; s < 128; s++)
      for (int w = 0; w < 4; w++) begin
        m_tag[s][w] = '0; m_valid[s][w] = 0; m_dirty[s][w] = 0;
      end
    clear_lru();
    last_hit = -1; last_victim = -1; last_wb = -1;
    rst = 1'b1; ld = 1'b0; st = 1'b0; addr = '0; l2_ack = 1'b0;
    tag_loaded = '0; valid = '0; dirty = '0;

    @(posedge clk); #1;
    expect_cycle("reset0", E_IDLE, 0, 1'b1);
    ld = 1'b1;
    expect_cycle("reset_ld_ignored", E_IDLE, 0, 1'b1);
    ld = 1'b0;
    rst = 1'b0;

    // Plain load hit; a stray l2_ack must not disturb anything.
    m_tag[8'h23][2] = 21'h2; m_valid[8'h23][2] = 1;
    l2_ack = 1'b1;
    access("t1", 1, 0, 2, 'h23, 0, 0, 0, 0);
    check("t1_addr", addr, 32'h0000_1230);
    l2_ack = 1'b0;
    check("t1_model_way", 32'(last_hit), 32'd2);
    expect_cycle("t1_idle", E_IDLE, 0, 1'b1);

    // Store miss into an all-invalid set, fill after a 3-cycle ack delay.
    for (int w = 0; w < 4; w++) m_valid[8'h23][w] = 0;
    access("t2", 0, 1, 2, 'h23, 0, 3, 0, 0);
    check("t2_model_victim", 32'(last_victim), 32'd0);
    check("t2_model_dirty", 32'(m_dirty[8'h23][0]), 32'd1);

    // Full set, PLRU all zero, dirty way 0 -> write-back then fill.
    for (int w = 0; w < 4; w++) begin
      m_tag[8'h10][w] = TAG_W'(5 + w); m_valid[8'h10][w] = 1;
    end
    m_dirty[8'h10][0] = 1;
    access("t3", 1, 0, 9, 'h10, 2, 1, 0, 0);
    check("t3_model_wb", 32'(last_wb), 32'd0);

    // Touch ways 0..3 in set 5; the tree then points back at way 0.
    for (int w = 0; w < 4; w++) begin
      m_tag[5][w] = TAG_W'(1 + w); m_valid[5][w] = 1;
    end
    for (int w = 0; w < 4; w++) access("t4h", 1, 0, 1 + w, 5, 0, 0, 0, 0);
    check("t4_model_plru", 32'(model_victim(5)), 32'd0);
    access("t4m", 1, 0, 7, 5, 0, 0, 0, 0);
    check("t4_model_victim", 32'(last_victim), 32'd0);

    // ld and st together behave as a load; ld during ALLOCATE is ignored.
    access("t5", 1, 1, 2, 5, 0, 0, 0, 0);
    check("t5_model_way", 32'(last_hit), 32'd1);
    access("t5a", 1, 0, 9, 5, 0, 2, 1, 0);
    check("t5a_model_victim", 32'(last_victim), 32'd2);

    // Reset mid write-back, then the same miss picks way 0 from a cleared tree.
    for (int w = 0; w < 4; w++) m_dirty[8'h10][w] = 1;
    access("t6", 1, 0, 'hA, 'h10, 0, 0, 0, 1);
    check("t6_model_wb_pre", 32'(last_wb), 32'd2);
    access("t6b", 1, 0, 'hA, 'h10, 1, 0, 0, 0);
    check("t6b_model_wb", 32'(last_wb), 32'd0);
    expect_cycle("final_idle", E_IDLE, 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
